// File: rtl/ecc_fifo_pkg.sv
// Shared definitions for the Core2 FIFO host-side dispatcher: widths,
// FSM state encodings and Core2 core-select command codes.
package ecc_fifo_pkg;

    localparam int OPW  = 128;
    localparam int DATA = 256;
    localparam int CMDW = 4;

    typedef enum logic {
        ISS_IDLE = 1'b0,
        ISS_PUSH = 1'b1
    } iss_state_t;

    typedef enum logic [1:0] {
        DR_IDLE = 2'd0,
        DR_WAIT = 2'd1,
        DR_HOLD = 2'd2
    } dr_state_t;

    // Core select values carried on job_cmd[2:0]
    localparam logic [2:0] CMD_CORE0 = 3'd0;
    localparam logic [2:0] CMD_CORE1 = 3'd1;
    localparam logic [2:0] CMD_CORE2 = 3'd2;
    localparam logic [2:0] CMD_CORE3 = 3'd3;
    localparam logic [2:0] CMD_CORE4 = 3'd4;
    localparam logic [2:0] CMD_CORE5 = 3'd5;
    localparam logic [2:0] CMD_CORE6 = 3'd6;
    localparam logic [2:0] CMD_CORE7 = 3'd7;

endpackage

// File: rtl/ecc_result_drain.sv
// Drains the Core2 output FIFO (1-cycle read latency) into a held
// valid/ready result register; res_done pulses on each result handshake.
module ecc_result_drain #(
    parameter int RES_W = ecc_fifo_pkg::DATA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             out_busy_out,
    output logic             rd_en_out,
    input  logic [RES_W-1:0] data_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_data,
    output logic             res_done,
    output logic             drain_idle
);
    import ecc_fifo_pkg::*;

    dr_state_t        state_reg, state_next;
    logic [RES_W-1:0] res_data_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= DR_IDLE;
            res_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DR_WAIT) begin
                res_data_reg <= data_out;
            end
        end
    end

    // A read is only issued from DR_IDLE, so nothing is fetched while a result is held
    always_comb begin
        state_next = state_reg;
        rd_en_out  = 1'b0;
        res_valid  = 1'b0;
        res_done   = 1'b0;
        case (state_reg)
            DR_IDLE: begin
                if (!out_busy_out) begin
                    rd_en_out  = 1'b1;
                    state_next = DR_WAIT;
                end
            end
            DR_WAIT: state_next = DR_HOLD;
            DR_HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    res_done   = 1'b1;
                    state_next = DR_IDLE;
                end
            end
            default: state_next = DR_IDLE;
        endcase
    end

    assign res_data   = res_data_reg;
    assign drain_idle = (state_reg == DR_IDLE);

endmodule

// File: rtl/ecc_job_dispatcher.sv
// Core2 FIFO initiator: issues jobs into the input/command FIFOs under a
// credit limit and drains results. Optional counters: ECC_DISPATCH_STATS_EN.
module ecc_job_dispatcher #(
    parameter int DATA    = ecc_fifo_pkg::DATA,
    parameter int OPW     = ecc_fifo_pkg::OPW,
    parameter int CMDW    = ecc_fifo_pkg::CMDW,
    parameter int MAX_OUT = 8,
    parameter int CW      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            job_valid,
    output logic            job_ready,
    input  logic [OPW-1:0]  job_a,
    input  logic [OPW-1:0]  job_b,
    input  logic [CMDW-1:0] job_cmd,
    output logic            wr_en_inp,
    output logic [OPW-1:0]  data_a,
    output logic [OPW-1:0]  data_b,
    input  logic            in_busy_inp,
    output logic            wr_en_cmd,
    output logic [CMDW-1:0] data_cmd,
    input  logic            in_busy_cmd,
    output logic            rd_en_out,
    input  logic [DATA-1:0] data_out,
    input  logic            out_busy_out,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [DATA-1:0] res_data,
    output logic [CW-1:0]   in_flight,
    output logic            idle
`ifdef ECC_DISPATCH_STATS_EN
    ,
    output logic [31:0]     jobs_issued,
    output logic [31:0]     results_returned
`endif
);
    import ecc_fifo_pkg::*;

    localparam logic [CW-1:0] MAX_CREDIT = CW'(MAX_OUT);

    iss_state_t      iss_state_reg, iss_state_next;
    logic [OPW-1:0]  data_a_reg, data_b_reg;
    logic [CMDW-1:0] data_cmd_reg;
    logic [CW-1:0]   in_flight_reg, in_flight_next;
    logic            accept;
    logic            res_done;
    logic            drain_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_state_reg <= ISS_IDLE;
            data_a_reg    <= '0;
            data_b_reg    <= '0;
            data_cmd_reg  <= '0;
            in_flight_reg <= '0;
        end else begin
            iss_state_reg <= iss_state_next;
            in_flight_reg <= in_flight_next;
            if (accept) begin
                data_a_reg   <= job_a;
                data_b_reg   <= job_b;
                data_cmd_reg <= job_cmd;
            end
        end
    end

    // The PUSH cycle gives the FIFO full flags a cycle to reflect the write
    always_comb begin
        iss_state_next = iss_state_reg;
        job_ready      = 1'b0;
        wr_en_inp      = 1'b0;
        wr_en_cmd      = 1'b0;
        case (iss_state_reg)
            ISS_IDLE: begin
                job_ready = !in_busy_inp && !in_busy_cmd && (in_flight_reg < MAX_CREDIT);
                if (job_valid && job_ready) begin
                    iss_state_next = ISS_PUSH;
                end
            end
            ISS_PUSH: begin
                wr_en_inp      = 1'b1;
                wr_en_cmd      = 1'b1;
                iss_state_next = ISS_IDLE;
            end
            default: iss_state_next = ISS_IDLE;
        endcase
    end

    assign accept = job_valid && job_ready;

    // Handshake with no credits outstanding is a protocol error; hold at zero
    always_comb begin
        in_flight_next = in_flight_reg;
        if (accept && !res_done) begin
            in_flight_next = in_flight_reg + 1'b1;
        end else if (!accept && res_done && (in_flight_reg != '0)) begin
            in_flight_next = in_flight_reg - 1'b1;
        end
    end

    ecc_result_drain #(
        .RES_W (DATA)
    ) u_drain (
        .clk          (clk),
        .rst          (rst),
        .out_busy_out (out_busy_out),
        .rd_en_out    (rd_en_out),
        .data_out     (data_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_done     (res_done),
        .drain_idle   (drain_idle)
    );

    assign data_a    = data_a_reg;
    assign data_b    = data_b_reg;
    assign data_cmd  = data_cmd_reg;
    assign in_flight = in_flight_reg;
    assign idle      = (iss_state_reg == ISS_IDLE) && drain_idle && (in_flight_reg == '0);

`ifdef ECC_DISPATCH_STATS_EN
    logic [31:0] jobs_issued_reg, results_returned_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            jobs_issued_reg      <= '0;
            results_returned_reg <= '0;
        end else begin
            if (wr_en_inp) jobs_issued_reg      <= jobs_issued_reg + 32'd1;
            if (res_done)  results_returned_reg <= results_returned_reg + 32'd1;
        end
    end

    assign jobs_issued      = jobs_issued_reg;
    assign results_returned = results_returned_reg;
`endif

endmodule

// File: tb/tb_ecc_job_dispatcher.sv
// Self-checking bench for ecc_job_dispatcher: a transaction-level model of the
// FIFOs and credit rules, directed scenarios, then a randomized soak.
module tb_ecc_job_dispatcher;

    localparam int MAX_OUT = 8;
    localparam int CW      = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [127:0] job_a = '0;
    logic [127:0] job_b = '0;
    logic [3:0]   job_cmd = '0;
    logic         wr_en_inp, wr_en_cmd, rd_en_out;
    logic [127:0] data_a, data_b;
    logic [3:0]   data_cmd;
    logic         in_busy_inp = 1'b0;
    logic         in_busy_cmd = 1'b0;
    logic [255:0] data_out = '0;
    logic         out_busy_out = 1'b1;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [255:0] res_data;
    logic [CW-1:0] in_flight;
    logic         idle;
`ifdef ECC_DISPATCH_STATS_EN
    logic [31:0]  jobs_issued, results_returned;
`endif

    always #5 clk = ~clk;

    ecc_job_dispatcher #(
        .MAX_OUT (MAX_OUT),
        .CW      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_a        (job_a),
        .job_b        (job_b),
        .job_cmd      (job_cmd),
        .wr_en_inp    (wr_en_inp),
        .data_a       (data_a),
        .data_b       (data_b),
        .in_busy_inp  (in_busy_inp),
        .wr_en_cmd    (wr_en_cmd),
        .data_cmd     (data_cmd),
        .in_busy_cmd  (in_busy_cmd),
        .rd_en_out    (rd_en_out),
        .data_out     (data_out),
        .out_busy_out (out_busy_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .in_flight    (in_flight),
        .idle         (idle)
`ifdef ECC_DISPATCH_STATS_EN
        ,
        .jobs_issued      (jobs_issued),
        .results_returned (results_returned)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transaction-level model state
    logic [255:0] fifo_q[$];
    logic [255:0] res_q[$];
    int           m_inflight = 0;
    bit           last_acc = 0;
    bit           post_rst = 0;
    logic [127:0] exp_a = '0, exp_b = '0;
    logic [3:0]   exp_cmd = '0;
    int           n_acc = 0, n_hs = 0;
    int           s_jobs = 0, s_res = 0;
    bit           s_idle, s_acc, s_hs;
    logic [255:0] last_res = '0;
    bit           rand_mode = 0;
    bit           use_fixed = 0;
    logic [255:0] fixed_res = '0;
    int           valid_pct = 50, busy_pct = 20, ready_pct = 50;

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [127:0] rand128();
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock: check at negedge, update model at posedge, then drive next inputs
    task automatic cycle();
        bit was_rst, push, rd;
        logic [255:0] v;
        @(negedge clk);
        was_rst = rst;
        s_acc   = job_valid && job_ready;
        s_hs    = res_valid && res_ready;
        push    = wr_en_inp;
        rd      = rd_en_out;
        s_idle  = idle;
        if (post_rst) begin
            chk("rst_wr_inp", 256'(wr_en_inp), 256'(0));
            chk("rst_wr_cmd", 256'(wr_en_cmd), 256'(0));
            chk("rst_rd_en", 256'(rd_en_out), 256'(0));
            chk("rst_res_valid", 256'(res_valid), 256'(0));
            chk("rst_res_data", res_data, 256'(0));
            chk("rst_data_a", 256'(data_a), 256'(0));
            chk("rst_data_cmd", 256'(data_cmd), 256'(0));
            chk("rst_in_flight", 256'(in_flight), 256'(0));
            chk("rst_idle", 256'(idle), 256'(1));
            post_rst = 0;
        end
        if (!was_rst) begin
            chk("in_flight", 256'(in_flight), 256'(m_inflight));
            chk("job_ready", 256'(job_ready),
                256'(!in_busy_inp && !in_busy_cmd && (m_inflight < MAX_OUT) && !last_acc));
            chk("wr_en_inp", 256'(wr_en_inp), 256'(last_acc));
            chk("wr_en_cmd", 256'(wr_en_cmd), 256'(last_acc));
            if (push) begin
                chk("data_a", 256'(data_a), 256'(exp_a));
                chk("data_b", 256'(data_b), 256'(exp_b));
                chk("data_cmd", 256'(data_cmd), 256'(exp_cmd));
            end
            chk("rd_safe", 256'(rd && (out_busy_out || res_valid)), 256'(0));
            if (s_hs) begin
                if (res_q.size() == 0) begin
                    chk("res_spurious", 256'(1), 256'(0));
                end else begin
                    v = res_q.pop_front();
                    chk("res_data", res_data, v);
                    last_res = v;
                end
            end
`ifdef ECC_DISPATCH_STATS_EN
            chk("jobs_issued", 256'(jobs_issued), 256'(s_jobs));
            chk("results_returned", 256'(results_returned), 256'(s_res));
`endif
            if (s_acc) begin
                exp_a   = job_a;
                exp_b   = job_b;
                exp_cmd = job_cmd;
            end
        end
        @(posedge clk);
        #1;
        if (was_rst) begin
            fifo_q.delete();
            res_q.delete();
            m_inflight = 0;
            last_acc   = 0;
            s_jobs     = 0;
            s_res      = 0;
            post_rst   = 1;
            data_out   = rand256();
        end else begin
            last_acc = s_acc;
            if (s_acc && !s_hs) m_inflight++;
            else if (s_hs && !s_acc && m_inflight > 0) m_inflight--;
            n_acc += int'(s_acc);
            n_hs  += int'(s_hs);
            s_jobs += int'(push);
            s_res  += int'(s_hs);
            if (rd && fifo_q.size() > 0) begin
                v = fifo_q.pop_front();
                res_q.push_back(v);
                data_out = v;
            end else begin
                data_out = rand256();
            end
            if (push) fifo_q.push_back(use_fixed ? fixed_res : rand256());
        end
        out_busy_out = (fifo_q.size() == 0);
        if (rand_mode) begin
            job_valid   = ($urandom_range(99) < valid_pct);
            job_a       = rand128();
            job_b       = rand128();
            job_cmd     = 4'($urandom);
            in_busy_inp = ($urandom_range(99) < busy_pct);
            in_busy_cmd = ($urandom_range(99) < busy_pct);
            res_ready   = ($urandom_range(99) < ready_pct);
        end
    endtask

    task automatic drain(input string tag);
        bit done = 0;
        rand_mode   = 0;
        job_valid   = 0;
        in_busy_inp = 0;
        in_busy_cmd = 0;
        res_ready   = 1;
        for (int i = 0; i < 300 && !done; i++) begin
            cycle();
            done = s_idle && (fifo_q.size() == 0) && (res_q.size() == 0);
        end
        chk(tag, 256'(done), 256'(1));
    endtask

    task automatic do_reset();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        cycle();
    endtask

    initial begin
        int a0;
        do_reset();

        // Single job with a fixed result
        use_fixed = 1;
        fixed_res = 256'hABCD;
        job_valid = 1; job_a = 128'h1; job_b = 128'h2; job_cmd = 4'b0001; res_ready = 1;
        a0 = n_acc;
        cycle();
        job_valid = 0;
        chk("single_in_flight1", 256'(in_flight), 256'(1));
        drain("single_drain");
        chk("single_accepts", 256'(n_acc - a0), 256'(1));
        chk("single_result", last_res, 256'hABCD);
        use_fixed = 0;
        $display("single job: in_flight=%0d res=%0h", in_flight, last_res);

        // Credit limit with downstream stalled
        res_ready = 0; job_valid = 1;
        a0 = n_acc;
        for (int i = 0; i < 30; i++) begin
            job_a = rand128(); job_b = rand128(); job_cmd = 4'($urandom);
            cycle();
        end
        chk("credit_accepts", 256'(n_acc - a0), 256'(MAX_OUT));
        chk("credit_in_flight", 256'(in_flight), 256'(MAX_OUT));
        chk("credit_ready", 256'(job_ready), 256'(0));
        $display("credit limit: accepts=%0d in_flight=%0d", n_acc - a0, in_flight);
        drain("credit_drain");

        // Command FIFO full blocks issue
        in_busy_cmd = 1; in_busy_inp = 0; job_valid = 1; res_ready = 1;
        a0 = n_acc;
        for (int i = 0; i < 5; i++) cycle();
        chk("busy_no_accept", 256'(n_acc - a0), 256'(0));
        in_busy_cmd = 0;
        cycle();
        chk("busy_resume", 256'(n_acc - a0), 256'(1));
        job_valid = 0;
        $display("full flags: accepts after release=%0d", n_acc - a0);
        drain("busy_drain");

        // Accept and handshake in the same cycle at in_flight=3
        res_ready = 0; job_valid = 1;
        a0 = n_acc;
        for (int i = 0; i < 20 && (n_acc - a0) < 3; i++) cycle();
        job_valid = 0;
        for (int i = 0; i < 20 && !(res_valid && job_ready); i++) cycle();
        chk("simul_setup", 256'(in_flight), 256'(3));
        job_valid = 1; res_ready = 1;
        cycle();
        job_valid = 0; res_ready = 0;
        chk("simul_events", 256'({s_acc, s_hs}), 256'(2'b11));
        chk("simul_in_flight", 256'(in_flight), 256'(3));
        $display("simultaneous: acc=%0d hs=%0d in_flight=%0d", s_acc, s_hs, in_flight);
        drain("simul_drain");

        // Reset during ISS_PUSH
        job_valid = 1; res_ready = 0;
        cycle();
        job_valid = 0;
        chk("rst_push_setup", 256'(wr_en_inp), 256'(1));
        rst = 1;
        cycle();
        rst = 0;
        cycle();
        $display("reset in push: in_flight=%0d idle=%0d", in_flight, idle);

        // Reset during DR_HOLD
        job_valid = 1; res_ready = 0;
        cycle();
        job_valid = 0;
        for (int i = 0; i < 20 && !res_valid; i++) cycle();
        chk("rst_hold_setup", 256'(res_valid), 256'(1));
        rst = 1;
        cycle();
        rst = 0;
        cycle();
        $display("reset in hold: res_valid=%0d in_flight=%0d idle=%0d", res_valid, in_flight, idle);

`ifdef ECC_DISPATCH_STATS_EN
        do_reset();
        job_valid = 1; res_ready = 1;
        a0 = n_acc;
        for (int i = 0; i < 40 && (n_acc - a0) < 5; i++) cycle();
        drain("stats_drain");
        chk("stats_jobs", 256'(jobs_issued), 256'(5));
        chk("stats_results", 256'(results_returned), 256'(5));
        $display("stats: jobs_issued=%0d results_returned=%0d", jobs_issued, results_returned);
`endif

        // Randomized soak
        rand_mode = 1;
        valid_pct = 60; busy_pct = 15; ready_pct = 50;
        a0 = n_acc;
        for (int i = 0; i < 3000; i++) cycle();
        drain("random_drain");
        chk("random_balance", 256'(n_acc - a0 > 0), 256'(1));
        $display("random: accepts=%0d handshakes=%0d", n_acc - a0, n_hs);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
